hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage RV32I core. Drives hold (stall) and bubble (flush) controls for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Resolves load-use hazards, taken-branch redirects and variable-latency data-memory accesses through a req/ready handshake, and traps a hung memory access after a fixed timeout.

---
 rtl/hazard_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Pipeline sequencing controller for the 5-stage RV32I core.
//                Produces hold (stall*) and bubble (flush*) controls for the
//                IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves
//                load-use hazards, taken-branch redirects and
//                variable-latency data-memory accesses, and traps a hung
//                memory access after MEM_TIMEOUT wait cycles.
//  Ports       : CLK, NRST (async, active-low)
//                rs1D/rs2D/use_rs1D/use_rs2D : decode source operands
//                rdE/mem_loadE/reg_writeE     : execute destination / load
//                branch_takenE                : execute redirects the PC
//                mem_loadM/mem_storeM         : memory-stage access type
//                dmem_ready / dmem_req        : data memory handshake
//                stallF/D/E/M, flushD/E/W     : pipeline controls
//                mem_err                      : sticky timeout flag
//                stall_cnt                    : stall-cycle counter
//  Options     : HAZARD_PERF_CNT_EN builds the saturating stall counter;
//                without it stall_cnt is tied to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        NRST,
  input  logic [4:0]  rs1D,
  input  logic [4:0]  rs2D,
  input  logic        use_rs1D,
  input  logic        use_rs2D,
  input  logic [4:0]  rdE,
  input  logic [2:0]  mem_loadE,
  input  logic        reg_writeE,
  input  logic        branch_takenE,
  input  logic [2:0]  mem_loadM,
  input  logic [1:0]  mem_storeM,
  input  logic        dmem_ready,
  output logic        dmem_req,
  output logic        stallF,
  output logic        stallD,
  output logic        stallE,
  output logic        stallM,
  output logic        flushD,
  output logic        flushE,
  output logic        flushW,
  output logic        mem_err,
  output logic [31:0] stall_cnt
);

  typedef enum logic [1:0] {
    INIT = 2'd0,
    RUN  = 2'd1,
    MEMW = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  state_t     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       mem_err_q, mem_err_d;
  logic       memopM;
  logic       load_use;

  assign memopM = (mem_loadM != 3'd0) | (mem_storeM != 2'd0);

  // x0 is never a real dependency, so a load targeting it cannot stall.
  assign load_use = (mem_loadE != 3'd0) & reg_writeE & (rdE != 5'd0) &
                    ((use_rs1D & (rs1D == rdE)) | (use_rs2D & (rs2D == rdE)));

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state_q    <= INIT;
      wait_cnt_q <= 8'd0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    dmem_req   = 1'b0;
    stallF     = 1'b0;
    stallD     = 1'b0;
    stallE     = 1'b0;
    stallM     = 1'b0;
    flushD     = 1'b0;
    flushE     = 1'b0;
    flushW     = 1'b0;

    unique case (state_q)
      INIT: begin
        // One bubble cycle clears whatever the pipeline registers hold.
        flushD  = 1'b1;
        flushE  = 1'b1;
        flushW  = 1'b1;
        state_d = RUN;
      end

      RUN: begin
        dmem_req = memopM;
        if (memopM && !dmem_ready) begin
          stallF     = 1'b1;
          stallD     = 1'b1;
          stallE     = 1'b1;
          stallM     = 1'b1;
          flushW     = 1'b1;
          wait_cnt_d = 8'd1;
          state_d    = MEMW;
        end else if (branch_takenE) begin
          // Wrong-path instructions in D and E are discarded; any load-use
          // match involves a squashed instruction and is irrelevant.
          flushD = 1'b1;
          flushE = 1'b1;
        end else if (load_use) begin
          stallF = 1'b1;
          stallD = 1'b1;
          flushE = 1'b1;
        end
      end

      MEMW: begin
        dmem_req = 1'b1;
        if (dmem_ready) begin
          // Pipeline advances; hazards are re-evaluated next cycle in RUN.
          state_d = RUN;
        end else begin
          stallF = 1'b1;
          stallD = 1'b1;
          stallE = 1'b1;
          stallM = 1'b1;
          flushW = 1'b1;
          if (wait_cnt_q == TIMEOUT_CNT) begin
            state_d   = ERR;
            mem_err_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end
      end

      ERR: begin
        stallF = 1'b1;
        stallD = 1'b1;
        stallE = 1'b1;
        stallM = 1'b1;
        flushW = 1'b1;
      end

      default: state_d = INIT;
    endcase
  end

  assign mem_err = mem_err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stallF && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Self-checking bench for hazard_ctrl (MEM_TIMEOUT = 4).
//                Directed scenarios followed by randomized traffic, compared
//                every cycle against a behavioural model of the sequencing
//                rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  localparam int TO = 4;

  logic        CLK = 1'b0;
  logic        NRST = 1'b0;
  logic [4:0]  rs1D = '0, rs2D = '0, rdE = '0;
  logic        use_rs1D = 1'b0, use_rs2D = 1'b0, reg_writeE = 1'b0;
  logic [2:0]  mem_loadE = '0, mem_loadM = '0;
  logic [1:0]  mem_storeM = '0;
  logic        branch_takenE = 1'b0, dmem_ready = 1'b1;
  logic        dmem_req, stallF, stallD, stallE, stallM;
  logic        flushD, flushE, flushW, mem_err;
  logic [31:0] stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: "fresh" = first cycle after reset, "waiting" = an access is
  // outstanding with n_wait cycles spent waiting, "trapped" = timed out.
  bit          m_fresh;
  bit          m_waiting;
  int          m_wait;
  bit          m_trapped;
  longint      m_stalls;

  hazard_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .CLK(CLK), .NRST(NRST),
    .rs1D(rs1D), .rs2D(rs2D), .use_rs1D(use_rs1D), .use_rs2D(use_rs2D),
    .rdE(rdE), .mem_loadE(mem_loadE), .reg_writeE(reg_writeE),
    .branch_takenE(branch_takenE), .mem_loadM(mem_loadM),
    .mem_storeM(mem_storeM), .dmem_ready(dmem_ready), .dmem_req(dmem_req),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .flushW(flushW), .mem_err(mem_err),
    .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit memop();
    return (mem_loadM != 0) || (mem_storeM != 0);
  endfunction

  function automatic bit hazard();
    return (mem_loadE != 0) && reg_writeE && (rdE != 0) &&
           ((use_rs1D && rs1D == rdE) || (use_rs2D && rs2D == rdE));
  endfunction

  // Expected {dmem_req, stallF, stallD, stallE, stallM, flushD, flushE, flushW, mem_err}
  function automatic logic [8:0] expect_ctl();
    bit req = 0, sf = 0, sd = 0, se = 0, sm = 0, fd = 0, fe = 0, fw = 0;
    if (!NRST || m_fresh) begin
      fd = 1; fe = 1; fw = 1;
    end else if (m_trapped) begin
      sf = 1; sd = 1; se = 1; sm = 1; fw = 1;
    end else if (m_waiting) begin
      req = 1;
      if (!dmem_ready) begin sf = 1; sd = 1; se = 1; sm = 1; fw = 1; end
    end else begin
      req = memop();
      if (memop() && !dmem_ready) begin
        sf = 1; sd = 1; se = 1; sm = 1; fw = 1;
      end else if (branch_takenE) begin
        fd = 1; fe = 1;
      end else if (hazard()) begin
        sf = 1; sd = 1; fe = 1;
      end
    end
    return {req, sf, sd, se, sm, fd, fe, fw, m_trapped};
  endfunction

  function automatic logic [31:0] expect_cnt();
`ifdef HAZARD_PERF_CNT_EN
    return (m_stalls > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(m_stalls);
`else
    return 32'd0;
`endif
  endfunction

  task automatic model_reset();
    m_fresh = 1; m_waiting = 0; m_wait = 0; m_trapped = 0; m_stalls = 0;
  endtask

  task automatic model_step(input logic [8:0] e);
    if (!NRST) begin
      model_reset();
      return;
    end
    if (e[7]) m_stalls++;
    if (m_fresh) begin
      m_fresh = 0;
    end else if (m_trapped) begin
      // only reset leaves the trap
    end else if (m_waiting) begin
      if (dmem_ready)        m_waiting = 0;
      else if (m_wait == TO) begin m_waiting = 0; m_trapped = 1; end
      else                   m_wait++;
    end else if (memop() && !dmem_ready) begin
      m_waiting = 1; m_wait = 1;
    end
  endtask

  // Caller sets inputs just after a rising edge; outputs are sampled mid-cycle.
  task automatic cycle(input string tag);
    logic [8:0] e;
    #3;
    e = expect_ctl();
    chk(tag, {23'd0, dmem_req, stallF, stallD, stallE, stallM,
              flushD, flushE, flushW, mem_err}, {23'd0, e});
    chk({tag, "_cnt"}, stall_cnt, expect_cnt());
    @(posedge CLK);
    model_step(e);
    #1;
  endtask

  task automatic idle_inputs();
    rs1D = 0; rs2D = 0; rdE = 0; use_rs1D = 0; use_rs2D = 0; reg_writeE = 0;
    mem_loadE = 0; mem_loadM = 0; mem_storeM = 0; branch_takenE = 0;
    dmem_ready = 1;
  endtask

  task automatic do_reset();
    NRST = 0;
    model_reset();
    #1;
    chk("rst_async", {23'd0, dmem_req, stallF, stallD, stallE, stallM,
                      flushD, flushE, flushW, mem_err}, {23'd0, expect_ctl()});
    @(posedge CLK); #1;
    cycle("rst_hold");
    cycle("rst_hold");
    NRST = 1;
  endtask

  task automatic rand_inputs();
    rs1D = 5'($urandom_range(0, 7));
    rs2D = 5'($urandom_range(0, 7));
    rdE  = 5'($urandom_range(0, 7));
    use_rs1D = 1'($urandom); use_rs2D = 1'($urandom);
    reg_writeE = ($urandom_range(0, 3) != 0);
    mem_loadE = ($urandom_range(0, 1) != 0) ? 3'($urandom_range(1, 7)) : 3'd0;
    branch_takenE = ($urandom_range(0, 4) == 0);
    mem_loadM = 0; mem_storeM = 0;
    if ($urandom_range(0, 3) == 0) begin
      if ($urandom_range(0, 1) != 0) mem_loadM = 3'($urandom_range(1, 7));
      else                           mem_storeM = 2'($urandom_range(1, 3));
    end
    dmem_ready = ($urandom_range(0, 9) >= 4);
  endtask

  initial begin
    idle_inputs();
    model_reset();
    @(posedge CLK); #1;
    do_reset();
    cycle("init_flush");
    cycle("run_idle");

    // Load-use: lw x5 in E, decode reads x5 via rs1
    rdE = 5; mem_loadE = 3'b010; reg_writeE = 1; rs1D = 5; use_rs1D = 1;
    cycle("load_use");
    idle_inputs();
    cycle("load_use_done");
    rdE = 0; mem_loadE = 3'b010; reg_writeE = 1; rs1D = 0; use_rs1D = 1;
    cycle("load_use_x0");

    // Branch wins over a simultaneous load-use match
    rdE = 7; rs2D = 7; use_rs2D = 1; branch_takenE = 1;
    cycle("branch_lu");
    idle_inputs();

    // Store with three cycles of dmem_ready low
    mem_storeM = 2'b01; dmem_ready = 0;
    repeat (3) cycle("mem_wait");
    dmem_ready = 1;
    cycle("mem_done");
    idle_inputs();
    cycle("after_mem");

    // Ready on the timeout cycle: RUN miss + 3 MEMW low, then 4th MEMW ready
    mem_loadM = 3'b010; dmem_ready = 0;
    repeat (4) cycle("to_edge_wait");
    dmem_ready = 1;
    cycle("to_edge_ready");
    idle_inputs();
    cycle("to_edge_run");

    // Hung load: enter ERR and stay there
    mem_loadM = 3'b010; dmem_ready = 0;
    repeat (5) cycle("timeout_wait");
    repeat (3) cycle("timeout_err");
    dmem_ready = 1;
    cycle("err_sticky");
    do_reset();
    idle_inputs();
    cycle("init_after_err");
    cycle("run_after_err");

    // Reset asserted mid-wait drops dmem_req at once
    mem_storeM = 2'b10; dmem_ready = 0;
    repeat (2) cycle("abort_wait");
    #2;
    do_reset();
    idle_inputs();
    cycle("init_after_abort");

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      rand_inputs();
      if ((m_trapped && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        cycle("random");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
